// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU: word width, reset/bubble
// constants, next-PC source selection and word-alignment helper.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] ALIGN_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_HOLD   = 2'd3
    } npc_sel_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds fetched instruction, its PC+4 and a valid bit.
// Stall holds all fields; flush inserts a bubble; reset clears to a bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] pcp4_in,
    input  logic [WORD_W-1:0] instr_in,
    output logic [WORD_W-1:0] pcp4,
    output logic [WORD_W-1:0] instr,
    output logic              valid
);

    logic [WORD_W-1:0] pcp4_d,  pcp4_q;
    logic [WORD_W-1:0] instr_d, instr_q;
    logic              valid_d, valid_q;

    // Next-state selection: stall outranks flush; the bubble still loads pcp4_in.
    always_comb begin
        pcp4_d  = pcp4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (stall) begin
            pcp4_d  = pcp4_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (flush) begin
            pcp4_d  = pcp4_in;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            pcp4_d  = pcp4_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    // Register update with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcp4_q  <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pcp4_q  <= pcp4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pcp4  = pcp4_q;
    assign instr = instr_q;
    assign valid = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage front end: program counter with next-PC selection (stall, branch,
// jump, sequential) and the IF/ID pipeline register. All outputs registered.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    input  logic [WORD_W-1:0] pcp4_in,
    input  logic [WORD_W-1:0] instr_in,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] if_id_pcp4,
    output logic [WORD_W-1:0] if_id_instr,
    output logic              if_id_valid
);

    npc_sel_e          npc_sel;
    logic [WORD_W-1:0] pc_d, pc_q;
    logic              redirect;

    // Next-PC source priority; a branch beats a simultaneous (illegal) jump.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (pc_stall) begin
            npc_sel = NPC_HOLD;
        end else if (branch_taken) begin
            npc_sel = NPC_BRANCH;
        end else if (jump) begin
            npc_sel = NPC_JUMP;
        end else begin
            npc_sel = NPC_SEQ;
        end
    end

    // Next-PC mux; every loaded address is word-aligned, arithmetic wraps mod 2^32.
    always_comb begin
        pc_d = pc_q;
        case (npc_sel)
            NPC_HOLD:   pc_d = pc_q;
            NPC_BRANCH: pc_d = word_align(branch_target);
            NPC_JUMP:   pc_d = word_align(jump_target);
            NPC_SEQ:    pc_d = word_align(pcp4_in);
            default:    pc_d = pc_q;
        endcase
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out   = pc_q;
    assign redirect = branch_taken | jump;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (pc_stall),
        .flush    (redirect),
        .pcp4_in  (pcp4_in),
        .instr_in (instr_in),
        .pcp4     (if_id_pcp4),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// control traffic, compared against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXP_NOP      = 32'h0000_0000;
    localparam logic [31:0] IMEM_KEY     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pcp4_in;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_pcp4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  skew;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic        m_pcp4_known;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return addr ^ IMEM_KEY;
    endfunction

    // External PC+4 adder (optionally skewed to exercise alignment) and imem.
    assign pcp4_in  = pc_out + 32'd4 + {30'd0, skew};
    assign instr_in = imem(pc_out);

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_stall      (pc_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pcp4_in       (pcp4_in),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_id_pcp4    (if_id_pcp4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic [1:0] sk);
        logic [31:0] raw_pcp4;
        logic [31:0] fetched;
        reset         = rst;
        pc_stall      = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        skew          = sk;
        raw_pcp4 = m_pc + 32'd4 + {30'd0, sk};
        fetched  = imem(m_pc);
        if (rst) begin
            m_pc = EXP_RESET_PC; m_instr = EXP_NOP; m_pcp4 = 32'd0;
            m_valid = 1'b0; m_pcp4_known = 1'b1;
        end else if (st) begin
            // hold everything
        end else if (br || jp) begin
            m_pc    = (br ? bt : jt) & ~32'd3;
            m_instr = EXP_NOP;
            m_valid = 1'b0;
            m_pcp4_known = 1'b0;
        end else begin
            m_pc    = raw_pcp4 & ~32'd3;
            m_instr = fetched;
            m_pcp4  = raw_pcp4;
            m_valid = 1'b1;
            m_pcp4_known = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("pc", pc_out, m_pc);
        check_eq("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check_eq("instr", if_id_instr, m_instr);
        if (m_pcp4_known) check_eq("pcp4", if_id_pcp4, m_pcp4);
    endtask

    task automatic seq();
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
    endtask

    task automatic br_to(input logic [31:0] t);
        cycle(1'b0, 1'b0, 1'b1, t, 1'b0, 32'd0, 2'd0);
    endtask

    initial begin
        reset = 1'b1; pc_stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_target = 32'd0; skew = 2'd0;
        m_pc = 32'd0; m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0; m_pcp4_known = 1'b0;

        // Reset and sequential fetch
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rst_pcp4", if_id_pcp4, 32'h0);
        seq();
        check_eq("seq1_pc", pc_out, 32'h4);
        check_eq("seq1_pcp4", if_id_pcp4, 32'h4);
        check_eq("seq1_valid", {31'd0, if_id_valid}, 32'd1);
        seq();
        check_eq("seq2_pc", pc_out, 32'h8);
        check_eq("seq2_pcp4", if_id_pcp4, 32'h8);

        // Taken branch at pc=8
        br_to(32'h40);
        check_eq("br_pc", pc_out, 32'h40);
        check_eq("br_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("br_bubble_instr", if_id_instr, 32'h0);
        seq();
        check_eq("br_tgt_instr", if_id_instr, imem(32'h40));
        check_eq("br_tgt_pcp4", if_id_pcp4, 32'h44);
        check_eq("br_tgt_valid", {31'd0, if_id_valid}, 32'd1);

        // Stall with simultaneous jump at pc=0x10
        br_to(32'hC);
        seq();
        check_eq("st_pre_pc", pc_out, 32'h10);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 2'd0);
        check_eq("st1_pc", pc_out, 32'h10);
        check_eq("st1_instr", if_id_instr, imem(32'hC));
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 2'd0);
        check_eq("st2_pc", pc_out, 32'h10);
        check_eq("st2_pcp4", if_id_pcp4, 32'h10);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 2'd0);
        check_eq("jmp_pc", pc_out, 32'h80);
        check_eq("jmp_valid", {31'd0, if_id_valid}, 32'd0);

        // Branch beats jump, target aligned
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'h200, 2'd0);
        check_eq("prio_pc", pc_out, 32'h100);

        // Wrap-around
        br_to(32'hFFFF_FFFC);
        seq();
        check_eq("wrap_pc", pc_out, 32'h0);
        check_eq("wrap_pcp4", if_id_pcp4, 32'h0);

        // Reset mid-stall
        br_to(32'h20);
        seq();
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
        check_eq("rs_pre_pc", pc_out, 32'h24);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
        check_eq("rs_pc", pc_out, EXP_RESET_PC);
        check_eq("rs_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("rs_instr", if_id_instr, EXP_NOP);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_st, r_br, r_jp;
            logic [1:0] r_sk;
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 4) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            r_jp  = ($urandom_range(0, 5) == 0);
            r_sk  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            cycle(r_rst, r_st, r_br, $urandom, r_jp, $urandom, r_sk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
